// File: rtl/apb_pkg.sv
// Shared definitions for the APB slave controller.
//   apb_state_e   : controller FSM states
//   Pprot*Bit     : bit positions inside PPROT
//   PslverrOk/Err : PSLVERR response codes
//   word_aligned(): true when an address is a multiple of the bus word size
package apb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StResp,
    StErr
  } apb_state_e;

  localparam int unsigned PprotPrivBit   = 0;
  localparam int unsigned PprotNsBit     = 1;
  localparam int unsigned PprotInstrBit  = 2;

  localparam logic PslverrOk  = 1'b0;
  localparam logic PslverrErr = 1'b1;

  // bytes is a power of two, so alignment is a mask test on the low bits.
  function automatic logic word_aligned(input logic [63:0] addr, input int unsigned bytes);
    logic [63:0] mask;
    mask = 64'(bytes) - 64'd1;
    return (addr & mask) == 64'd0;
  endfunction

endpackage

// File: rtl/apb_timeout_counter.sv
// Counts cycles spent waiting on the backend.
//   pclk, preset : clock and synchronous active-high reset
//   clear        : force the count back to zero (has priority over enable)
//   enable       : advance the count by one this cycle
//   expired      : count has reached TIMEOUT_CYCLES-1
module apb_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic pclk,
  input  logic preset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] count_q;

  assign expired = (count_q == CntMax);

  always_ff @(posedge pclk) begin
    if (preset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && !expired) begin
      // Saturate so a non power-of-two limit never wraps past CntMax.
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/apb_slave_ctrl.sv
// APB completer that forwards decoded transfers to a simple request/valid backend.
//   pclk, preset            : clock, synchronous active-high reset
//   paddr..pstrb            : APB request inputs
//   pready, prdata, pslverr : APB response (all registered)
//   slave_*  (outputs)      : latched request presented to the backend while slave_req is high
//   slave_data_valid, slave_read_data, slave_error : backend completion
// Transfers outside [BASE_ADDR, BASE_ADDR+ADDR_SPAN) or not word aligned are answered with an
// immediate error. A silent backend is cut off after TIMEOUT_CYCLES request cycles.
module apb_slave_ctrl
  import apb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned BYTES_PER_WORD = DATA_WIDTH / 8,
  parameter int unsigned BASE_ADDR      = 0,
  parameter int unsigned ADDR_SPAN      = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic [ADDR_WIDTH-1:0]     paddr,
  input  logic [2:0]                pprot,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [DATA_WIDTH-1:0]     pwdata,
  input  logic [BYTES_PER_WORD-1:0] pstrb,
  output logic                      pready,
  output logic [DATA_WIDTH-1:0]     prdata,
  output logic                      pslverr,
  output logic                      slave_req,
  output logic [ADDR_WIDTH-1:0]     slave_address,
  output logic [2:0]                slave_protection,
  output logic                      slave_read_write,
  output logic [DATA_WIDTH-1:0]     slave_write_data,
  output logic [BYTES_PER_WORD-1:0] slave_strobe,
  input  logic                      slave_data_valid,
  input  logic [DATA_WIDTH-1:0]     slave_read_data,
  input  logic                      slave_error
);

  apb_state_e                state_q;
  logic                      pready_q;
  logic                      pslverr_q;
  logic [DATA_WIDTH-1:0]     prdata_q;
  logic                      slave_req_q;
  logic [ADDR_WIDTH-1:0]     slave_address_q;
  logic [2:0]                slave_protection_q;
  logic                      slave_read_write_q;
  logic [DATA_WIDTH-1:0]     slave_write_data_q;
  logic [BYTES_PER_WORD-1:0] slave_strobe_q;

  logic        timeout_expired;
  logic        addr_ok;
  logic [63:0] addr_offset;

  // Offset arithmetic in 64 bits: an address below the base wraps to a huge
  // offset, so one unsigned compare covers both ends of the window.
  always_comb begin
    addr_offset = 64'(paddr) - 64'(BASE_ADDR);
    addr_ok     = (addr_offset < 64'(ADDR_SPAN)) && word_aligned(64'(paddr), BYTES_PER_WORD);
  end

  apb_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .pclk    (pclk),
    .preset  (preset),
    .clear   (state_q != StReq),
    .enable  (state_q == StReq),
    .expired (timeout_expired)
  );

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q            <= StIdle;
      pready_q           <= 1'b0;
      pslverr_q          <= PslverrOk;
      prdata_q           <= '0;
      slave_req_q        <= 1'b0;
      slave_address_q    <= '0;
      slave_protection_q <= '0;
      slave_read_write_q <= 1'b0;
      slave_write_data_q <= '0;
      slave_strobe_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // psel with penable already high is a protocol violation and is ignored.
          if (psel && !penable) begin
            slave_address_q    <= paddr - ADDR_WIDTH'(BASE_ADDR);
            slave_protection_q <= pprot;
            slave_read_write_q <= pwrite;
            slave_write_data_q <= pwdata;
            slave_strobe_q     <= pstrb;
            if (addr_ok) begin
              state_q     <= StReq;
              slave_req_q <= 1'b1;
            end else begin
              state_q   <= StErr;
              pready_q  <= 1'b1;
              pslverr_q <= PslverrErr;
              prdata_q  <= '0;
            end
          end
        end
        StReq: begin
          if (!psel) begin
            // Master abandoned the transfer: no response is produced.
            state_q     <= StIdle;
            slave_req_q <= 1'b0;
          end else if (slave_data_valid) begin
            state_q     <= StResp;
            slave_req_q <= 1'b0;
            pready_q    <= 1'b1;
            pslverr_q   <= slave_error;
            prdata_q    <= slave_read_write_q ? '0 : slave_read_data;
          end else if (timeout_expired) begin
            state_q     <= StResp;
            slave_req_q <= 1'b0;
            pready_q    <= 1'b1;
            pslverr_q   <= PslverrErr;
            prdata_q    <= '0;
          end
        end
        StResp, StErr: begin
          state_q   <= StIdle;
          pready_q  <= 1'b0;
          pslverr_q <= PslverrOk;
          prdata_q  <= '0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign pready           = pready_q;
  assign pslverr          = pslverr_q;
  assign prdata           = prdata_q;
  assign slave_req        = slave_req_q;
  assign slave_address    = slave_address_q;
  assign slave_protection = slave_protection_q;
  assign slave_read_write = slave_read_write_q;
  assign slave_write_data = slave_write_data_q;
  assign slave_strobe     = slave_strobe_q;

endmodule

// File: tb/tb_apb_slave_ctrl.sv
// Randomised bench for apb_slave_ctrl with a transfer-level reference model.
module tb_apb_slave_ctrl;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 10;
  localparam int unsigned BPW  = 4;
  localparam int unsigned BASE = 0;
  localparam int unsigned SPAN = 768;
  localparam int unsigned TO   = 16;

  logic           pclk;
  logic           preset;
  logic [AW-1:0]  paddr;
  logic [2:0]     pprot;
  logic           psel;
  logic           penable;
  logic           pwrite;
  logic [DW-1:0]  pwdata;
  logic [BPW-1:0] pstrb;
  logic           pready;
  logic [DW-1:0]  prdata;
  logic           pslverr;
  logic           slave_req;
  logic [AW-1:0]  slave_address;
  logic [2:0]     slave_protection;
  logic           slave_read_write;
  logic [DW-1:0]  slave_write_data;
  logic [BPW-1:0] slave_strobe;
  logic           slave_data_valid;
  logic [DW-1:0]  slave_read_data;
  logic           slave_error;

  int n_vec = 0;
  int n_err = 0;

  apb_slave_ctrl #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .BYTES_PER_WORD (BPW),
    .BASE_ADDR      (BASE),
    .ADDR_SPAN      (SPAN),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .pclk             (pclk),
    .preset           (preset),
    .paddr            (paddr),
    .pprot            (pprot),
    .psel             (psel),
    .penable          (penable),
    .pwrite           (pwrite),
    .pwdata           (pwdata),
    .pstrb            (pstrb),
    .pready           (pready),
    .prdata           (prdata),
    .pslverr          (pslverr),
    .slave_req        (slave_req),
    .slave_address    (slave_address),
    .slave_protection (slave_protection),
    .slave_read_write (slave_read_write),
    .slave_write_data (slave_write_data),
    .slave_strobe     (slave_strobe),
    .slave_data_valid (slave_data_valid),
    .slave_read_data  (slave_read_data),
    .slave_error      (slave_error)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_req"}, 64'(slave_req), 64'd0);
    check_eq({tag, "_pready"}, 64'(pready), 64'd0);
    check_eq({tag, "_pslverr"}, 64'(pslverr), 64'd0);
    check_eq({tag, "_prdata"}, 64'(prdata), 64'd0);
  endtask

  // One APB transfer. delay = REQ cycle (1-based) on which the backend answers;
  // 0 or > TO means it stays silent. kill_mode 1 = psel drop, 2 = reset, at REQ cycle kill_at.
  task automatic xfer(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wdata,
                      input logic [BPW-1:0] strb, input logic [2:0] prot, input int delay,
                      input logic berr, input logic [DW-1:0] rdata,
                      input int kill_mode, input int kill_at);
    bit            bad;
    bit            timed_out;
    int            exp_n;
    int            n_req;
    bit            killed;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;

    // Reference outcome straight from the transfer rules.
    bad       = (int'(addr) < int'(BASE)) || (int'(addr) >= int'(BASE + SPAN)) ||
                (int'(addr) % int'(BPW) != 0);
    timed_out = !(delay >= 1 && delay <= int'(TO));
    exp_n     = bad ? 0 : (timed_out ? int'(TO) : delay);
    exp_err   = bad || timed_out || berr;
    exp_rdata = (bad || timed_out || wr) ? '0 : rdata;

    // Setup phase; a stray backend valid here must be ignored.
    psel             = 1'b1;
    penable          = 1'b0;
    paddr            = addr;
    pwrite           = wr;
    pwdata           = wdata;
    pstrb            = strb;
    pprot            = prot;
    slave_data_valid = 1'($urandom);
    slave_read_data  = $urandom;
    slave_error      = 1'($urandom);
    check_eq("setup_pready", 64'(pready), 64'd0);
    check_eq("setup_req", 64'(slave_req), 64'd0);
    tick();
    penable = 1'b1;
    // Later changes on the bus must not disturb the latched request.
    paddr   = AW'($urandom);
    pwdata  = $urandom;
    pstrb   = BPW'($urandom);
    pprot   = 3'($urandom);

    n_req  = 0;
    killed = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (!slave_req) break;
      n_req++;
      check_eq("req_addr", 64'(slave_address), 64'(addr - AW'(BASE)));
      check_eq("req_prot", 64'(slave_protection), 64'(prot));
      check_eq("req_rw", 64'(slave_read_write), 64'(wr));
      check_eq("req_wdata", 64'(slave_write_data), 64'(wdata));
      check_eq("req_strb", 64'(slave_strobe), 64'(strb));
      check_eq("req_pready", 64'(pready), 64'd0);
      check_eq("req_prdata", 64'(prdata), 64'd0);
      slave_data_valid = (n_req == delay);
      slave_read_data  = (n_req == delay) ? rdata : $urandom;
      slave_error      = (n_req == delay) ? berr : 1'($urandom);
      if (kill_mode != 0 && n_req == kill_at) begin
        killed = 1'b1;
        if (kill_mode == 1) begin
          psel             = 1'b0;
          penable          = 1'b0;
          slave_data_valid = 1'b0;
        end else begin
          preset           = 1'b1;
          slave_data_valid = 1'b1;
          slave_read_data  = rdata;
        end
        tick();
        preset           = 1'b0;
        psel             = 1'b0;
        penable          = 1'b0;
        slave_data_valid = 1'b0;
        check_quiet("kill");
        if (kill_mode == 2) begin
          check_eq("kill_addr", 64'(slave_address), 64'd0);
          check_eq("kill_strb", 64'(slave_strobe), 64'd0);
        end
        tick();
        check_quiet("kill_after");
        break;
      end
      tick();
    end
    if (kill_mode != 0) begin
      check_eq("kill_reached", 64'(killed), 64'd1);
      return;
    end

    check_eq("req_cycles", 64'(n_req), 64'(exp_n));
    check_eq("resp_pready", 64'(pready), 64'd1);
    check_eq("resp_pslverr", 64'(pslverr), 64'(exp_err));
    check_eq("resp_prdata", 64'(prdata), 64'(exp_rdata));
    check_eq("resp_req", 64'(slave_req), 64'd0);

    psel             = 1'b0;
    penable          = 1'b0;
    slave_data_valid = 1'($urandom);
    tick();
    slave_data_valid = 1'b0;
    check_quiet("post");
  endtask

  initial begin
    psel             = 1'b0;
    penable          = 1'b0;
    paddr            = '0;
    pprot            = '0;
    pwrite           = 1'b0;
    pwdata           = '0;
    pstrb            = '0;
    slave_data_valid = 1'b0;
    slave_read_data  = '0;
    slave_error      = 1'b0;
    preset           = 1'b1;
    tick();
    tick();
    check_quiet("reset");
    check_eq("reset_addr", 64'(slave_address), 64'd0);
    check_eq("reset_rw", 64'(slave_read_write), 64'd0);
    preset = 1'b0;

    // First setup on the very first edge out of reset; read with three wait cycles.
    xfer(10'h010, 1'b0, '0, 4'hf, 3'd0, 3, 1'b0, 32'hDEADBEEF, 0, 0);
    xfer(10'h020, 1'b1, 32'h12345678, 4'b0101, 3'd2, 2, 1'b0, 32'hCAFEF00D, 0, 0);
    xfer(10'h402, 1'b0, '0, 4'hf, 3'd0, 1, 1'b0, 32'h1, 0, 0);
    xfer(10'h300, 1'b0, '0, 4'hf, 3'd0, 1, 1'b0, 32'h1, 0, 0);
    xfer(10'h2fc, 1'b0, '0, 4'hf, 3'd5, 1, 1'b1, 32'hA5A5A5A5, 0, 0);
    xfer(10'h040, 1'b0, '0, 4'hf, 3'd0, 0, 1'b0, 32'h55AA55AA, 0, 0);
    xfer(10'h044, 1'b0, '0, 4'hf, 3'd0, 16, 1'b0, 32'h0BADF00D, 0, 0);
    xfer(10'h048, 1'b0, '0, 4'hf, 3'd0, 17, 1'b0, 32'h0BADF00D, 0, 0);
    xfer(10'h050, 1'b0, '0, 4'hf, 3'd1, 5, 1'b0, 32'h1111, 2, 2);
    xfer(10'h054, 1'b0, '0, 4'hf, 3'd0, 2, 1'b0, 32'h22223333, 0, 0);
    xfer(10'h058, 1'b1, 32'h9, 4'h3, 3'd7, 5, 1'b0, 32'h1, 1, 1);
    xfer(10'h05c, 1'b0, '0, 4'hf, 3'd0, 1, 1'b0, 32'h44445555, 0, 0);

    // Access phase while idle must be ignored.
    psel    = 1'b1;
    penable = 1'b1;
    paddr   = 10'h010;
    tick();
    check_quiet("viol");
    tick();
    check_quiet("viol2");
    psel    = 1'b0;
    penable = 1'b0;
    tick();

    for (int i = 0; i < 40; i++) begin
      logic [AW-1:0] a;
      a = AW'($urandom);
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      xfer(a, 1'($urandom), $urandom, BPW'($urandom), 3'($urandom),
           int'($urandom_range(0, 18)), 1'($urandom), $urandom, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
